iterative_divider: RTL and testbench

// - Multi-cycle 32-bit integer divider for the execute stage; the division counterpart of the multiplier.
// - Implements RV32M DIV/DIVU/REM/REMU as a radix-2 restoring divider, one quotient bit per cycle.
// - Uses the same request/ready handshake as the multiplier, so the execute stage drives both identically.

---
 rtl/bolme_pkg.sv | 26 ++
 rtl/bolme_adimi.sv | 25 ++
 rtl/iterative_divider.sv | 142 ++++++++++++++
 tb/tb_iterative_divider.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bolme_pkg.sv
// Shared definitions for the iterative divider: FSM states, default width
// and the RISC-V special-case result constants.
package bolme_pkg;

    localparam int XLEN_VARSAYILAN = 32;

    // BOSTA: idle, BOL: one quotient bit per cycle, DUZELT: sign fix-up,
    // BITTI: normal completion pulse, OZEL: special-case completion pulse.
    typedef enum logic [2:0] {
        BOSTA  = 3'd0,
        BOL    = 3'd1,
        DUZELT = 3'd2,
        BITTI  = 3'd3,
        OZEL   = 3'd4
    } bolme_durum_e;

    // Most negative signed value; dividing it by -1 overflows.
    localparam logic [XLEN_VARSAYILAN-1:0] INT_MIN = {1'b1, {(XLEN_VARSAYILAN-1){1'b0}}};

    // Quotient returned for division by zero (all ones, both modes).
    localparam logic [XLEN_VARSAYILAN-1:0] SIFIRA_BOLUM_SONUC = {XLEN_VARSAYILAN{1'b1}};

    // Remainder returned for the signed overflow case.
    localparam logic [XLEN_VARSAYILAN-1:0] TASMA_KALAN_SONUC = '0;

endpackage

// File: rtl/bolme_adimi.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module bolme_adimi #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] kalan_i,
    input  logic [XLEN-1:0] bolum_i,
    input  logic [XLEN-1:0] bolen_i,
    output logic [XLEN-1:0] kalan_o,
    output logic [XLEN-1:0] bolum_o
);

    // The shifted remainder needs one extra bit: rem < d, so 2*rem+1 < 2^(XLEN+1).
    logic [XLEN:0] kaydirilmis;
    logic [XLEN:0] fark;
    logic          bolum_biti;

    assign kaydirilmis = {kalan_i, bolum_i[XLEN-1]};
    assign fark        = kaydirilmis - {1'b0, bolen_i};
    // No borrow means the divisor fit into the shifted remainder.
    assign bolum_biti  = ~fark[XLEN];
    assign kalan_o     = bolum_biti ? fark[XLEN-1:0] : kaydirilmis[XLEN-1:0];
    assign bolum_o     = {bolum_i[XLEN-2:0], bolum_biti};

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one
// quotient bit per cycle. Operands are held by the requester until the
// one-cycle bolme_hazir_o pulse; dropping blok_aktif_i while busy aborts.
module iterative_divider
    import bolme_pkg::*;
#(
    parameter int XLEN = XLEN_VARSAYILAN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            blok_aktif_i,
    input  logic            bolme_unsigned_i,
    input  logic            kalan_sec_i,
    input  logic [XLEN-1:0] bolunen_i,
    input  logic [XLEN-1:0] bolen_i,
    output logic [XLEN-1:0] sonuc_o,
    output logic            bolme_hazir_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    bolme_durum_e     durum_q;
    logic [CNT_W-1:0] sayac_q;
    logic [XLEN-1:0]  kalan_q;
    logic [XLEN-1:0]  bolum_q;
    logic [XLEN-1:0]  bolen_q;
    logic             bolum_negatif_q;
    logic             kalan_negatif_q;
    logic             kalan_sec_q;
    logic [XLEN-1:0]  sonuc_q;
    logic             hazir_q;

    logic [XLEN-1:0]  kalan_d;
    logic [XLEN-1:0]  bolum_d;
    logic             bolunen_neg;
    logic             bolen_neg;
    logic [XLEN-1:0]  bolunen_mutlak;
    logic [XLEN-1:0]  bolen_mutlak;
    logic             ozel_sifir;
    logic             ozel_tasma;

    // Magnitudes are only taken in signed mode; unsigned operands pass through.
    assign bolunen_neg    = ~bolme_unsigned_i & bolunen_i[XLEN-1];
    assign bolen_neg      = ~bolme_unsigned_i & bolen_i[XLEN-1];
    assign bolunen_mutlak = bolunen_neg ? (~bolunen_i + 1'b1) : bolunen_i;
    assign bolen_mutlak   = bolen_neg   ? (~bolen_i + 1'b1)   : bolen_i;

    assign ozel_sifir = (bolen_i == '0);
    assign ozel_tasma = ~bolme_unsigned_i && (bolunen_i == INT_MIN) && (bolen_i == '1);

    bolme_adimi #(
        .XLEN (XLEN)
    ) u_adim (
        .kalan_i (kalan_q),
        .bolum_i (bolum_q),
        .bolen_i (bolen_q),
        .kalan_o (kalan_d),
        .bolum_o (bolum_d)
    );

    // Control FSM, iteration datapath and registered result/pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q         <= BOSTA;
            sayac_q         <= '0;
            kalan_q         <= '0;
            bolum_q         <= '0;
            bolen_q         <= '0;
            bolum_negatif_q <= 1'b0;
            kalan_negatif_q <= 1'b0;
            kalan_sec_q     <= 1'b0;
            sonuc_q         <= '0;
            hazir_q         <= 1'b0;
        end else begin
            case (durum_q)
                BOSTA: begin
                    sonuc_q <= '0;
                    hazir_q <= 1'b0;
                    if (blok_aktif_i) begin
                        if (ozel_sifir) begin
                            durum_q <= OZEL;
                            hazir_q <= 1'b1;
                            sonuc_q <= kalan_sec_i ? bolunen_i : SIFIRA_BOLUM_SONUC;
                        end else if (ozel_tasma) begin
                            durum_q <= OZEL;
                            hazir_q <= 1'b1;
                            sonuc_q <= kalan_sec_i ? TASMA_KALAN_SONUC : INT_MIN;
                        end else begin
                            durum_q         <= BOL;
                            bolum_q         <= bolunen_mutlak;
                            bolen_q         <= bolen_mutlak;
                            kalan_q         <= '0;
                            sayac_q         <= CNT_W'(XLEN);
                            bolum_negatif_q <= bolunen_neg ^ bolen_neg;
                            kalan_negatif_q <= bolunen_neg;
                            kalan_sec_q     <= kalan_sec_i;
                        end
                    end
                end
                BOL: begin
                    if (!blok_aktif_i) begin
                        durum_q <= BOSTA;
                    end else begin
                        kalan_q <= kalan_d;
                        bolum_q <= bolum_d;
                        sayac_q <= sayac_q - 1'b1;
                        if (sayac_q == CNT_W'(1)) begin
                            durum_q <= DUZELT;
                        end
                    end
                end
                DUZELT: begin
                    if (!blok_aktif_i) begin
                        durum_q <= BOSTA;
                    end else begin
                        durum_q <= BITTI;
                        hazir_q <= 1'b1;
                        if (kalan_sec_q) begin
                            sonuc_q <= kalan_negatif_q ? (~kalan_q + 1'b1) : kalan_q;
                        end else begin
                            sonuc_q <= bolum_negatif_q ? (~bolum_q + 1'b1) : bolum_q;
                        end
                    end
                end
                BITTI, OZEL: begin
                    durum_q <= BOSTA;
                    hazir_q <= 1'b0;
                    sonuc_q <= '0;
                end
                default: begin
                    durum_q <= BOSTA;
                    hazir_q <= 1'b0;
                    sonuc_q <= '0;
                end
            endcase
        end
    end

    assign sonuc_o       = sonuc_q;
    assign bolme_hazir_o = hazir_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider: table of hand-computed
// operations, multi-cycle abort/reset/operand-change sequences and a short
// randomized sweep checked against a behavioural reference.
module tb_iterative_divider;

    logic        clk;
    logic        rst;
    logic        blok;
    logic        uns;
    logic        kal;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sonuc;
    logic        hazir;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        uns;
        logic        kal;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        logic        b2b;
    } vec_t;

    vec_t tbl[22];

    iterative_divider dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .blok_aktif_i     (blok),
        .bolme_unsigned_i (uns),
        .kalan_sec_i      (kal),
        .bolunen_i        (a),
        .bolen_i          (b),
        .sonuc_o          (sonuc),
        .bolme_hazir_o    (hazir)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic u, input logic r,
                                           input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return r ? x : 32'hFFFF_FFFF;
        if (u) return r ? (x % y) : (x / y);
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
        return r ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
    endfunction

    // Start an operation and wait for its pulse. Called at a negedge.
    // b2b=1: called in the pulse cycle of the previous op with blok still high.
    task automatic run_op(input string name, input logic u, input logic r,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int exp_lat, input logic b2b);
        int   lat;
        logic got;
        logic spurious;
        if (!b2b) begin
            blok = 1'b0;
            @(negedge clk);
        end
        uns  = u;
        kal  = r;
        a    = x;
        b    = y;
        blok = 1'b1;
        if (b2b) @(negedge clk);
        lat      = 0;
        got      = 1'b0;
        spurious = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (hazir) got = 1'b1;
            else if (sonuc != 32'd0) spurious = 1'b1;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, sonuc, exp);
        check({name, "_idle_zero"}, {31'd0, spurious}, 32'd0);
    endtask

    // Watch for a stray pulse or nonzero result over n cycles.
    task automatic expect_quiet(input string name, input int n);
        int pulses;
        int dirty;
        pulses = 0;
        dirty  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (hazir) pulses++;
            if (sonuc != 32'd0) dirty++;
        end
        check({name, "_pulses"}, 32'(pulses), 32'd0);
        check({name, "_result_zero"}, 32'(dirty), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 34, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 34, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'd5,         32'd0,         32'd5,         1,  1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b1};
        tbl[8]  = '{1'b1, 1'b0, 32'd0,         32'd5,         32'd0,         34, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'd0,         32'hFFFF_FFF9, 32'd0,         34, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'd3,         32'd16,        32'd0,         34, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 32'd3,         32'd16,        32'd3,         34, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'd16,        32'hFFFF_FFFD, 34, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         34, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 32'd7,         32'd0,         32'hFFFF_FFFF, 1,  1'b0};
        tbl[18] = '{1'b0, 1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 34, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        34, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, 1'b1};
        tbl[21] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1,  1'b0};

        // reset with a request pending: nothing may start or pulse
        rst  = 1'b1;
        blok = 1'b1;
        uns  = 1'b0;
        kal  = 1'b0;
        a    = 32'd5;
        b    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_hazir", {31'd0, hazir}, 32'd0);
        check("reset_sonuc", sonuc, 32'd0);
        blok = 1'b0;
        rst  = 1'b0;
        expect_quiet("post_reset", 3);

        // directed table
        for (int i = 0; i < 22; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].uns, tbl[i].kal, tbl[i].a, tbl[i].b,
                   tbl[i].exp, tbl[i].lat, tbl[i].b2b);
        end

        // drop the request at cycle 10: aborted, no pulse
        blok = 1'b0;
        @(negedge clk);
        uns  = 1'b1;
        kal  = 1'b0;
        a    = 32'd1000;
        b    = 32'd3;
        blok = 1'b1;
        repeat (10) @(negedge clk);
        blok = 1'b0;
        expect_quiet("abort", 45);

        // reset at cycle 20 of an operation: no pulse, then a clean DIVU
        blok = 1'b1;
        repeat (20) @(negedge clk);
        rst  = 1'b1;
        blok = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("midop_reset", 45);
        run_op("divu_after_reset", 1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 34, 1'b0);

        // operands changing while busy are ignored
        blok = 1'b0;
        @(negedge clk);
        uns  = 1'b1;
        kal  = 1'b1;
        a    = 32'd100;
        b    = 32'd7;
        blok = 1'b1;
        repeat (5) @(negedge clk);
        a = 32'd9;
        b = 32'd3;
        begin
            int lat;
            lat = 5;
            while (!hazir && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            check("operand_change_latency", 32'(lat), 32'd34);
            check("operand_change_result", sonuc, 32'd2);
        end

        // randomized sweep against the reference, with back-to-back requests
        for (int i = 0; i < 150; i++) begin
            logic        ru, rr, rb2b;
            logic [31:0] ra, rb;
            int          rl;
            ru   = 1'($urandom_range(0, 1));
            rr   = 1'($urandom_range(0, 1));
            rb2b = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'd0;
                2:       ra = 32'($urandom_range(0, 100));
                default: ra = $urandom;
            endcase
            rl = (rb == 32'd0 || (!ru && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 34;
            run_op($sformatf("rnd%0d", i), ru, rr, ra, rb, ref_div(ru, rr, ra, rb), rl, rb2b);
        end

        blok = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
